// File: rtl/iar_pkg.sv
// Shared constants and the default stack-entry type for the interrupt/exception
// return-address stack.
package iar_pkg;

  localparam int TRAP_OFFSET = 4;
  localparam int EXC_OFFSET  = 8;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0001_0000;
  localparam logic [31:0] DEF_VALID_LIMIT  = 32'h0001_0008;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  cause;
  } iar_entry_t;

endpackage

// File: rtl/iar_lifo.sv
// LIFO storage for return entries: push, pop, in-place replace of the top, and
// a combinational read of the top entry.
module iar_lifo
  import iar_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = iar_entry_t,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  entry_t        wr_data,
  output entry_t        top,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [LW-1:0] level_reg;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  // At level==DEPTH the low bits wrap to 0, so top_idx lands on DEPTH-1.
  assign top_idx = level_reg[AW-1:0] - AW'(1);
  assign wr_idx  = replace ? top_idx : level_reg[AW-1:0];

  always_ff @(posedge clk) begin
    if (push || replace) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= '0;
    end else if (push) begin
      level_reg <= level_reg + LW'(1);
    end else if (pop) begin
      level_reg <= level_reg - LW'(1);
    end
  end

  assign top   = mem[top_idx];
  assign level = level_reg;

endmodule

// File: rtl/iar_stack.sv
// Nested exception return-address stack: qualifies exceptions, computes the
// return address and drives push/pop/replace on the LIFO; tracks nesting errors.
module iar_stack
  import iar_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 4,
  parameter int                CAUSE_W      = 5,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [ADDR_W-1:0] VALID_LIMIT  = DEF_VALID_LIMIT,
  localparam int               LW           = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_8_in,
  input  logic               exception,
  input  logic               trap,
  input  logic               memwrite,
  input  logic               oint_ex,
  input  logic [CAUSE_W-1:0] cause_in,
  input  logic               eret,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic [LW-1:0]      level,
  output logic               empty,
  output logic               full,
  output logic               nest_err
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [CAUSE_W-1:0] cause;
  } entry_t;

  logic   trap_store;
  logic   capture;
  logic   push;
  logic   pop;
  logic   replace;
  logic   nest_err_reg;
  entry_t wr_entry;
  entry_t top_entry;

  assign trap_store = (memwrite & oint_ex) | trap;
  assign capture    = exception & (pc_8_in >= VALID_LIMIT);

  assign wr_entry.addr  = trap_store ? (pc_8_in - ADDR_W'(TRAP_OFFSET))
                                     : (pc_8_in - ADDR_W'(EXC_OFFSET));
  assign wr_entry.cause = cause_in;

  // A capture coinciding with eret on an empty stack has nothing to replace.
  assign push    = capture & (~eret | empty) & ~full;
  assign replace = capture & eret & ~empty;
  assign pop     = eret & ~capture & ~empty;

  iar_lifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .wr_data (wr_entry),
    .top     (top_entry),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      nest_err_reg <= 1'b0;
    end else if ((capture & ~eret & full) | (eret & ~capture & empty)) begin
      nest_err_reg <= 1'b1;
    end
  end

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign pc_out    = empty ? RESET_VECTOR : top_entry.addr;
  assign cause_out = empty ? '0 : top_entry.cause;
  assign nest_err  = nest_err_reg;

endmodule

// File: tb/tb_iar_stack.sv
// Self-checking bench for iar_stack: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_iar_stack;

  localparam logic [31:0] RV    = 32'h0001_0000;
  localparam logic [31:0] LIMIT = 32'h0001_0008;
  localparam int          DEP   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_8_in = '0;
  logic        exception = 1'b0;
  logic        trap = 1'b0;
  logic        memwrite = 1'b0;
  logic        oint_ex = 1'b0;
  logic [4:0]  cause_in = '0;
  logic        eret = 1'b0;
  logic [31:0] pc_out;
  logic [4:0]  cause_out;
  logic [2:0]  level;
  logic        empty;
  logic        full;
  logic        nest_err;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  c;
  } ent_t;

  ent_t q[$];
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  iar_stack dut (
    .clk       (clk),
    .reset     (reset),
    .pc_8_in   (pc_8_in),
    .exception (exception),
    .trap      (trap),
    .memwrite  (memwrite),
    .oint_ex   (oint_ex),
    .cause_in  (cause_in),
    .eret      (eret),
    .pc_out    (pc_out),
    .cause_out (cause_out),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .nest_err  (nest_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the stack rules.
  task automatic model(input logic rst, exc, tr, mw, oi, er,
                       input logic [31:0] pc, input logic [4:0] cs);
    logic cap;
    ent_t e;
    cap = exc && (pc >= LIMIT);
    e.a = ((mw && oi) || tr) ? pc - 32'd4 : pc - 32'd8;
    e.c = cs;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else if (cap && er && q.size() != 0) begin
      q[q.size()-1] = e;
    end else if (cap) begin
      if (q.size() < DEP) q.push_back(e);
      else m_err = 1'b1;
    end else if (er) begin
      if (q.size() == 0) m_err = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ep;
    logic [4:0]  ec;
    ep = (q.size() != 0) ? q[q.size()-1].a : RV;
    ec = (q.size() != 0) ? q[q.size()-1].c : 5'd0;
    chk({tag, ".pc"}, 64'(pc_out), 64'(ep));
    chk({tag, ".cause"}, 64'(cause_out), 64'(ec));
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".full"}, 64'(full), 64'(q.size() == DEP));
    chk({tag, ".nerr"}, 64'(nest_err), 64'(m_err));
  endtask

  task automatic cyc(input string tag, input logic rst, exc, tr, mw, oi, er,
                     input logic [31:0] pc, input logic [4:0] cs);
    reset = rst; exception = exc; trap = tr; memwrite = mw; oint_ex = oi;
    eret = er; pc_8_in = pc; cause_in = cs;
    model(rst, exc, tr, mw, oi, er, pc, cs);
    @(posedge clk);
    #1;
    check_all(tag);
    $display("txn %-8s rst=%0b exc=%0b trap=%0b mw=%0b oi=%0b eret=%0b pc=%08h -> pc_out=%08h lvl=%0d err=%0b",
             tag, rst, exc, tr, mw, oi, er, pc, pc_out, level, nest_err);
  endtask

  initial begin
    logic [31:0] addrs [5];
    addrs[0] = 32'h0001_1008; addrs[1] = 32'h0001_2008; addrs[2] = 32'h0001_3008;
    addrs[3] = 32'h0001_4008; addrs[4] = 32'h0001_5008;

    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", 64'(pc_out), 64'(RV));

    // Trap-style and plain exception return addresses.
    cyc("trap", 0, 1, 1, 0, 0, 0, 32'h0001_0100, 5'd3);
    chk("trap_pc", 64'(pc_out), 64'h0001_00FC);
    cyc("exc", 0, 1, 0, 0, 0, 0, 32'h0001_0100, 5'd4);
    chk("exc_pc", 64'(pc_out), 64'h0001_00F8);
    cyc("stst", 0, 1, 0, 1, 1, 0, 32'h0001_0200, 5'd5);
    chk("st_pc", 64'(pc_out), 64'h0001_01FC);

    // Reset in the same cycle as a capture.
    cyc("rstpush", 1, 1, 0, 0, 0, 0, 32'h0001_0300, 5'd6);
    chk("rp_lvl", 64'(level), 64'd0);

    // Below the valid limit, and exactly at it.
    cyc("below", 0, 1, 0, 0, 0, 0, 32'h0001_0004, 5'd1);
    chk("below_lvl", 64'(level), 64'd0);
    cyc("atlim", 0, 1, 0, 0, 0, 0, LIMIT, 5'd2);
    chk("atlim_pc", 64'(pc_out), 64'h0001_0000);
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0, 0);

    // Overflow then drain.
    for (int i = 0; i < 5; i++) cyc("push", 0, 1, 0, 0, 0, 0, addrs[i], 5'(i + 1));
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_top", 64'(pc_out), 64'(addrs[3] - 32'd8));
    chk("ovf_err", 64'(nest_err), 64'd1);
    for (int i = 3; i >= 0; i--) begin
      chk("drain_top", 64'(pc_out), 64'(addrs[i] - 32'd8));
      cyc("eret", 0, 0, 0, 0, 0, 1, 0, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_pc", 64'(pc_out), 64'(RV));

    // Replace at level 2, then confirm the lower entry survives.
    cyc("rst3", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("push", 0, 1, 0, 0, 0, 0, addrs[0], 5'd7);
    cyc("push", 0, 1, 0, 0, 0, 0, addrs[1], 5'd8);
    cyc("repl", 0, 1, 0, 0, 0, 1, 32'h0002_0008, 5'd9);
    chk("repl_lvl", 64'(level), 64'd2);
    chk("repl_pc", 64'(pc_out), 64'h0002_0000);
    cyc("eret", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("repl_low", 64'(pc_out), 64'(addrs[0] - 32'd8));
    cyc("eret", 0, 0, 0, 0, 0, 1, 0, 0);

    // Capture with eret on an empty stack acts as a push.
    cyc("replemp", 0, 1, 0, 0, 0, 1, 32'h0003_0008, 5'd10);
    chk("re_lvl", 64'(level), 64'd1);
    cyc("eret", 0, 0, 0, 0, 0, 1, 0, 0);

    // Underflow.
    cyc("undf", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("undf_err", 64'(nest_err), 64'd1);
    chk("undf_pc", 64'(pc_out), 64'(RV));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) == 0) ? 32'(LIMIT - 32'd8 + 32'($urandom_range(0, 15)))
                                       : $urandom;
      cyc("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
          pc, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
